// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART receive path
// Purpose: receiver FSM state encoding, frame data width and default bit timing.
// Ports: none (package).
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } rx_state_e;

  localparam int DATA_BITS            = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 434;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// rtl/uart_rx_fifo_if.sv - register-block side of the UART receive FIFO
// Purpose: groups the pop/status/interrupt signals between uart_rx_fifo and the register block.
// Ports (slave = uart_rx_fifo side):
//   rd_en_i, err_clr_i          : pop request and sticky-flag clear, driven by the register block
//   rd_data_o                   : FIFO head byte, first-word fall-through
//   rx_empty_o, rx_full_o       : FIFO status
//   rx_count_o                  : bytes held
//   frame_err_o, overrun_o      : sticky error flags
//   rx_irq_o                    : level interrupt
interface uart_rx_fifo_if #(
  parameter int FIFO_DEPTH = 8
);
  import uart_pkg::*;

  logic                          rd_en_i;
  logic                          err_clr_i;
  logic [DATA_BITS-1:0]          rd_data_o;
  logic                          rx_empty_o;
  logic                          rx_full_o;
  logic [$clog2(FIFO_DEPTH):0]   rx_count_o;
  logic                          frame_err_o;
  logic                          overrun_o;
  logic                          rx_irq_o;

  modport master (
    output rd_en_i, err_clr_i,
    input  rd_data_o, rx_empty_o, rx_full_o, rx_count_o, frame_err_o, overrun_o, rx_irq_o
  );

  modport slave (
    input  rd_en_i, err_clr_i,
    output rd_data_o, rx_empty_o, rx_full_o, rx_count_o, frame_err_o, overrun_o, rx_irq_o
  );

endinterface

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - single-clock first-word fall-through FIFO
// Purpose: circular buffer shared by the UART RX and TX paths.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   push, din    : write request and data
//   pop          : read request (ignored while empty)
//   dout         : head entry, 0 while empty
//   empty, full  : status
//   count        : entries held
//   drop         : one-cycle pulse when a push is lost to a full FIFO
module uart_sync_fifo #(
  parameter int  WIDTH = 8,
  parameter int  DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      count,
  output logic             drop
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             pop_ok;
  logic             push_ok;

  // Pointers carry one extra bit so full and empty are distinguishable.
  assign count = wr_ptr - rd_ptr;
  assign empty = (count == '0);
  assign full  = (count == DEPTH_C);

  // A pop in the same cycle frees the slot a full-FIFO push needs.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign drop    = push && full && !pop_ok;

  assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 8N1 UART receiver with byte FIFO and sticky error flags
// Purpose: synchronises the RX pad, deserialises frames and buffers bytes for the register block.
// Ports:
//   wb_clk_i : system clock
//   wb_rst_i : asynchronous active-low reset
//   rx_i     : raw serial input, idles high
//   bus      : register-block side (pop, status, error flags, interrupt)
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_i,
  input  logic           rx_i,
  uart_rx_fifo_if.slave  bus
);

  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT/2 - 1);
  localparam logic [15:0] FULL_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  BIT_LAST  = 3'(DATA_BITS - 1);

  rx_state_e            state_q, state_d;
  logic                 rx_meta, rx_s;
  logic [15:0]          baud_cnt;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 sample_bit;
  logic                 push;
  logic                 fe_set;
  logic                 drop;
  logic                 frame_err_q, overrun_q;

  // Two-flop synchroniser; idles high so reset never looks like a start bit.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_s    <= rx_meta;
    end
  end

  always_comb begin
    state_d    = state_q;
    sample_bit = 1'b0;
    push       = 1'b0;
    fe_set     = 1'b0;
    case (state_q)
      ST_IDLE:  if (!rx_s) state_d = ST_START;
      // Mid-start re-check filters short glitches on an idle line.
      ST_START: if (baud_cnt == HALF_LAST) state_d = rx_s ? ST_IDLE : ST_DATA;
      ST_DATA: begin
        if (baud_cnt == FULL_LAST) begin
          sample_bit = 1'b1;
          if (bit_idx == BIT_LAST) state_d = ST_STOP;
        end
      end
      // Leaving at mid-stop gives half a bit of slack for the next start edge.
      ST_STOP: begin
        if (baud_cnt == FULL_LAST) begin
          if (rx_s) begin
            push    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            fe_set  = 1'b1;
            state_d = ST_BREAK;
          end
        end
      end
      // A line held low must go high again before another frame is accepted.
      ST_BREAK: if (rx_s) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q  <= ST_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
    end else begin
      state_q <= state_d;
      // Restart bit timing on every state change and at each data-bit sample.
      if (state_d != state_q || sample_bit || state_q == ST_IDLE || state_q == ST_BREAK)
        baud_cnt <= '0;
      else
        baud_cnt <= baud_cnt + 16'd1;
      if (state_q == ST_START && state_d == ST_DATA)
        bit_idx <= '0;
      else if (sample_bit)
        bit_idx <= bit_idx + 3'd1;
      if (sample_bit) shift[bit_idx] <= rx_s;
    end
  end

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_i),
    .push  (push),
    .pop   (bus.rd_en_i),
    .din   (shift),
    .dout  (bus.rd_data_o),
    .empty (bus.rx_empty_o),
    .full  (bus.rx_full_o),
    .count (bus.rx_count_o),
    .drop  (drop)
  );

  // Sticky flags: a set event in the same cycle as err_clr_i wins.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (fe_set)             frame_err_q <= 1'b1;
      else if (bus.err_clr_i) frame_err_q <= 1'b0;
      if (drop)               overrun_q   <= 1'b1;
      else if (bus.err_clr_i) overrun_q   <= 1'b0;
    end
  end

  assign bus.frame_err_o = frame_err_q;
  assign bus.overrun_o   = overrun_q;
  assign bus.rx_irq_o    = !bus.rx_empty_o || frame_err_q || overrun_q;

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Serial receive front-end for the user-area UART. It samples the raw RX pad from io_in, deserialises 8N1 frames and buffers received bytes in a small FIFO. The Wishbone-side uart register block pops bytes from the FIFO and reads status and interrupt from it. The block sits directly upstream of the uart register block, between the GPIO pad and the bus logic.

Parameters:
CLKS_PER_BIT, 434, wb_clk_i cycles per bit (115200 baud at 50 MHz); legal range 4..65535.
FIFO_DEPTH, 8, entries in the byte FIFO; must be a power of 2, range 2..64.

Ports:
wb_clk_i  in  1  system clock; all logic is on the rising edge
wb_rst_i  in  1  asynchronous, active-low reset
rx_i  in  1  raw serial input from the pad, asynchronous to wb_clk_i; idles high
rd_en_i  in  1  pop request from the register block
rd_data_o  out  8  FIFO head byte, first-word fall-through
rx_empty_o  out  1  FIFO empty
rx_full_o  out  1  FIFO full
rx_count_o  out  $clog2(FIFO_DEPTH)+1  number of bytes held
frame_err_o  out  1  sticky flag: stop bit sampled low
overrun_o  out  1  sticky flag: byte dropped because the FIFO was full
err_clr_i  in  1  one-cycle pulse that clears both sticky flags
rx_irq_o  out  1  level interrupt, high while !rx_empty_o || frame_err_o || overrun_o

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - FSM goes to IDLE; both synchroniser flops go to 1.
  - FIFO is emptied; counters and flags are 0.
  - Output values: rd_data_o=0, rx_empty_o=1, rx_full_o=0, rx_count_o=0, frame_err_o=0, overrun_o=0, rx_irq_o=0.
  - A reset mid-frame discards the partial byte; no push occurs.
- Synchroniser: rx_i passes through 2 flops to give rx_s. All FSM decisions use rx_s only.
- Counters:
  - baud_cnt: 16 bits, cleared on every state change.
  - bit_idx: 3 bits.
  - shift: 8-bit register, loaded LSB first.
- FSM:
  - IDLE: when rx_s==0, go to START.
  - START: when baud_cnt==CLKS_PER_BIT/2-1, sample rx_s. If 1, treat as a glitch and return to IDLE. If 0, go to DATA with bit_idx=0.
  - DATA: when baud_cnt==CLKS_PER_BIT-1, shift in rx_s at bit position bit_idx. After bit_idx==7, go to STOP; otherwise increment bit_idx.
  - STOP: when baud_cnt==CLKS_PER_BIT-1, sample rx_s.
    - If 1: push shift into the FIFO and go to IDLE. Returning at mid-stop allows back-to-back frames.
    - If 0: set frame_err_o, discard the byte and go to BREAK.
  - BREAK: wait for rx_s==1, then go to IDLE. This prevents a held-low line from re-triggering reception.
- Push and FIFO timing:
  - The push happens on the cycle of the stop sample. The byte is visible on rd_data_o and rx_count_o on the next cycle.
  - Total latency from the rx_i stop-bit midpoint to data visible is 3 cycles (2 synchroniser + 1).
- FIFO rules:
  - Circular buffer with read and write pointers one bit wider than the address, for full/empty detection.
  - rd_en_i while empty: ignored; pointers unchanged.
  - Push while full with no pop in the same cycle: byte dropped and overrun_o set.
  - Push and pop in the same cycle while full: both are accepted, rx_count_o is unchanged and overrun_o is not set.
  - Push and pop in the same cycle while empty: push only; the pop is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- Sticky flags:
  - err_clr_i clears frame_err_o and overrun_o.
  - If a set event and err_clr_i occur in the same cycle, the set wins.
- rd_data_o shows mem[rd_ptr] while not empty and 0 while empty.

Decomposition:
- uart_pkg holds:
  - the FSM state encoding (IDLE, START, DATA, STOP, BREAK);
  - the constant DATA_BITS=8;
  - the default CLKS_PER_BIT.
- One sub-module, uart_sync_fifo, parameterised by width and depth. It exposes push, pop, din, dout, empty, full, count and a drop pulse. It will be reused by the TX path.

Test Plan:
- CLKS_PER_BIT=16. Send frame 0xA5 → after the stop midpoint plus 3 cycles: rx_empty_o=0, rd_data_o=0xA5, rx_count_o=1, rx_irq_o=1. Pulse rd_en_i → rx_empty_o=1 and rx_irq_o=0 on the next cycle.
- Send a 5-cycle low glitch on an idle line → FSM returns to IDLE, no push, no flags set.
- Send 0x3C with the stop bit driven low, then hold the line low for 40 bit times → frame_err_o=1, no push, and no further frames are detected until the line goes high. Pulse err_clr_i → frame_err_o=0.
- Send 9 back-to-back frames 0x00..0x08 with no reads → rx_full_o=1, rx_count_o=8, overrun_o=1. Pop all entries → bytes read in order 0x00..0x07.
- With the FIFO full, assert rd_en_i on exactly the push cycle of the 9th frame → overrun_o=0, rx_count_o stays 8, and the last byte is 0x08.
- Assert wb_rst_i low in the middle of DATA bit 4 → all outputs return to their reset values immediately. The next full frame 0x5A is then received correctly.
